// File: rtl/traffic_fsm_if.sv
// traffic_fsm_if: timer pulses, night level and lamp/status outputs of the traffic controller
interface traffic_fsm_if;
  logic       timeout30;
  logic       timeout45;
  logic       night;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       timer_rst;
  logic [7:0] cycle_cnt;
  logic       err;
  modport master (output timeout30, timeout45, night, input light_a, light_b, timer_rst, cycle_cnt, err);
  modport slave  (input timeout30, timeout45, night, output light_a, light_b, timer_rst, cycle_cnt, err);
endinterface

// File: rtl/traffic_fsm.sv
// traffic_fsm: two-approach light controller with night flashing, cycle count and sticky error flag
module traffic_fsm (
  input  logic         clk,
  input  logic         rst,
  traffic_fsm_if.slave bus
);
  typedef enum logic [2:0] {A_GREEN, A_YELLOW, B_GREEN, B_YELLOW, FLASH} state_t;
  state_t st, nxt;
  logic   blink, blink_nxt, green, yellow, viol;
  function automatic logic [5:0] lamps(state_t s, logic b);
    return s == A_GREEN  ? 6'b001_100 :
           s == A_YELLOW ? 6'b010_100 :
           s == B_GREEN  ? 6'b100_001 :
           s == B_YELLOW ? 6'b100_010 : {1'b0, ~b, 2'b00, ~b, 1'b0};
  endfunction
  always_comb begin
    green     = st == A_GREEN || st == B_GREEN;
    yellow    = st == A_YELLOW || st == B_YELLOW;
    viol      = (green && bus.timeout45) || (yellow && bus.timeout30);
    nxt       = st;
    if (st == FLASH) nxt = bus.night ? FLASH : A_GREEN;
    else if (bus.night) nxt = FLASH;
    else if (green && bus.timeout30) nxt = st == A_GREEN ? A_YELLOW : B_YELLOW;
    else if (yellow && bus.timeout45) nxt = st == A_YELLOW ? B_GREEN : A_GREEN;
    blink_nxt = nxt == FLASH && st == FLASH && !blink;
  end
  // Lamps are registered from the next state so they track the state register exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      st                     <= A_GREEN;
      blink                  <= 1'b0;
      {bus.light_a, bus.light_b} <= 6'b001_100;
      bus.timer_rst          <= 1'b0;
      bus.cycle_cnt          <= 8'd0;
      bus.err                <= 1'b0;
    end else begin
      st                     <= nxt;
      blink                  <= blink_nxt;
      {bus.light_a, bus.light_b} <= lamps(nxt, blink_nxt);
      bus.timer_rst          <= st == FLASH && !bus.night;
      bus.cycle_cnt          <= bus.cycle_cnt + {7'd0, st == B_YELLOW && nxt == A_GREEN};
      bus.err                <= bus.err | viol;
    end
  end
endmodule
